// File: rtl/switch_capture_unit.sv
// rtl/switch_capture_unit.sv - N-channel switch capture: synchronise, debounce, press pulse,
// wrapping event count, press-to-press period in prescaled ticks, shared elapsed-time counter.
`timescale 1ns/1ps
module switch_capture_unit #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int TIME_W     = 32,
  parameter int DEB_CYCLES = 16,
  parameter int PRESC      = 1000
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [N_CH-1:0]         nSw,
  input  logic [N_CH-1:0]         Clear,
  output logic [N_CH-1:0]         Press,
  output logic [N_CH*CNT_W-1:0]   Event_count,
  output logic [N_CH*CNT_W-1:0]   Period,
  output logic [N_CH-1:0]         Stopped,
  output logic [TIME_W-1:0]       Total_time
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRE_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PRE_W-1:0] presc_cnt;
  logic             tick;

  assign tick = (presc_cnt == PRE_LAST);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      presc_cnt  <= '0;
      Total_time <= '0;
    end else if (tick) begin
      presc_cnt  <= '0;
      Total_time <= Total_time + TIME_W'(1);
    end else begin
      presc_cnt  <= presc_cnt + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             sync1, sync2, deb, press_q, armed, stop;
    logic [DEB_W-1:0] deb_cnt;
    logic [CNT_W-1:0] ic, ev, per, ic_inc;

    assign ic_inc = (ic == CNT_MAX) ? ic : ic + CNT_W'(1);

    always_ff @(posedge HCLK) begin
      if (HRESET) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        deb     <= 1'b1;
        deb_cnt <= '0;
        press_q <= 1'b0;
        ic      <= '0;
        ev      <= '0;
        per     <= '0;
        armed   <= 1'b0;
        stop    <= 1'b0;
      end else begin
        sync1   <= nSw[i];
        sync2   <= sync1;
        press_q <= 1'b0;

        // Any bounce back to the accepted level restarts the stability count.
        if (sync2 != deb) begin
          if (deb_cnt == DEB_LAST) begin
            deb     <= sync2;
            deb_cnt <= '0;
            press_q <= ~sync2;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_cnt <= '0;
        end

        // The registered press pulse is consumed here, one edge after it appears.
        if (Clear[i]) begin
          ic    <= '0;
          ev    <= '0;
          per   <= '0;
          armed <= 1'b0;
          stop  <= 1'b0;
        end else if (press_q) begin
          ev <= ev + CNT_W'(1);
          if (armed) per <= tick ? ic_inc : ic;
          ic    <= '0;
          armed <= 1'b1;
          stop  <= 1'b0;
        end else if (tick) begin
          ic <= ic_inc;
          if (armed && ic_inc == CNT_MAX) begin
            per  <= CNT_MAX;
            stop <= 1'b1;
          end
        end
      end
    end

    assign Press[i]                       = press_q;
    assign Stopped[i]                     = stop;
    assign Event_count[i*CNT_W +: CNT_W]  = ev;
    assign Period[i*CNT_W +: CNT_W]       = per;
  end

endmodule

// File: tb/tb_switch_capture_unit.sv
// tb/tb_switch_capture_unit.sv - bench for switch_capture_unit: directed vector table and
// hand sequences plus randomized switch activity against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_switch_capture_unit;

  localparam int NC  = 4;
  localparam int CW  = 8;
  localparam int TW  = 16;
  localparam int DEB = 4;
  localparam int PA  = 1;
  localparam int PB  = 3;
  localparam int MX  = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] nsw = '1;
  logic [NC-1:0] clr = '0;

  logic [NC-1:0]    a_press, b_press, a_stop, b_stop;
  logic [NC*CW-1:0] a_ev, b_ev, a_per, b_per;
  logic [TW-1:0]    a_time, b_time;

  switch_capture_unit #(.N_CH(NC), .CNT_W(CW), .TIME_W(TW), .DEB_CYCLES(DEB), .PRESC(PA)) u_a (
    .HCLK(clk), .HRESET(rst), .nSw(nsw), .Clear(clr), .Press(a_press),
    .Event_count(a_ev), .Period(a_per), .Stopped(a_stop), .Total_time(a_time));

  switch_capture_unit #(.N_CH(NC), .CNT_W(CW), .TIME_W(TW), .DEB_CYCLES(DEB), .PRESC(PB)) u_b (
    .HCLK(clk), .HRESET(rst), .nSw(nsw), .Clear(clr), .Press(b_press),
    .Event_count(b_ev), .Period(b_per), .Stopped(b_stop), .Total_time(b_time));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fld(input logic [NC*CW-1:0] v, input int c);
    return int'((v >> (c * CW)) & 32'hFF);
  endfunction

  // Reference model: debounce as run length of raw samples (seen two edges late),
  // period and stop derived from the edge timestamps of consumed presses.
  int       edge_n;
  logic [NC-1:0] s_d1, s_d2;
  int       run_len [NC];
  logic     run_val [NC];
  logic     m_deb   [NC];
  logic     m_press [NC];
  int       m_cnt   [NC];
  bit       m_armed [NC];
  int       m_last  [NC];
  int       m_per   [2][NC];
  bit       m_stop  [2][NC];

  function automatic int pv(input int k);
    return (k == 0) ? PA : PB;
  endfunction

  function automatic int ticks(input int e1, input int e2, input int p);
    return (e2 / p) - (e1 / p);
  endfunction

  task automatic model_step();
    logic v;
    int   t;
    if (rst) begin
      edge_n = 0;
      s_d1 = '1;
      s_d2 = '1;
      for (int c = 0; c < NC; c++) begin
        run_len[c] = DEB; run_val[c] = 1'b1; m_deb[c] = 1'b1; m_press[c] = 1'b0;
        m_cnt[c] = 0; m_armed[c] = 0; m_last[c] = 0;
        for (int k = 0; k < 2; k++) begin m_per[k][c] = 0; m_stop[k][c] = 0; end
      end
    end else begin
      edge_n++;
      for (int c = 0; c < NC; c++) begin
        if (clr[c]) begin
          m_cnt[c] = 0; m_armed[c] = 0;
          for (int k = 0; k < 2; k++) begin m_per[k][c] = 0; m_stop[k][c] = 0; end
        end else if (m_press[c]) begin
          m_cnt[c] = (m_cnt[c] + 1) % 256;
          if (m_armed[c])
            for (int k = 0; k < 2; k++) begin
              t = ticks(m_last[c], edge_n, pv(k));
              m_per[k][c] = (t > MX) ? MX : t;
            end
          m_last[c] = edge_n; m_armed[c] = 1;
          for (int k = 0; k < 2; k++) m_stop[k][c] = 0;
        end else if (m_armed[c]) begin
          for (int k = 0; k < 2; k++)
            if (ticks(m_last[c], edge_n, pv(k)) >= MX) begin
              m_per[k][c] = MX; m_stop[k][c] = 1;
            end
        end
        v = s_d2[c];
        if (v == run_val[c]) run_len[c]++;
        else begin run_val[c] = v; run_len[c] = 1; end
        m_press[c] = 1'b0;
        if (v != m_deb[c] && run_len[c] >= DEB) begin
          m_deb[c] = v;
          m_press[c] = ~v;
        end
      end
      s_d2 = s_d1;
      s_d1 = nsw;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    chk_en = 1;
  end

  logic [NC-1:0]    xp_press, xa_stop, xb_stop;
  logic [NC*CW-1:0] xp_ev, xa_per, xb_per;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        xp_press[c]        = m_press[c];
        xa_stop[c]         = m_stop[0][c];
        xb_stop[c]         = m_stop[1][c];
        xp_ev[c*CW +: CW]  = 8'(m_cnt[c]);
        xa_per[c*CW +: CW] = 8'(m_per[0][c]);
        xb_per[c*CW +: CW] = 8'(m_per[1][c]);
      end
      cmp("a.press", a_press, xp_press);
      cmp("a.count", a_ev, xp_ev);
      cmp("a.period", a_per, xa_per);
      cmp("a.stopped", a_stop, xa_stop);
      cmp("a.time", a_time, 16'(edge_n / PA));
      cmp("b.press", b_press, xp_press);
      cmp("b.count", b_ev, xp_ev);
      cmp("b.period", b_per, xb_per);
      cmp("b.stopped", b_stop, xb_stop);
      cmp("b.time", b_time, 16'(edge_n / PB));
    end
  end

  typedef struct {
    logic [NC-1:0] nsw;
    logic [NC-1:0] clr;
    int            hold;
    int            ch;
    int            ev;
    int            per;
    logic          stp;
  } vec_t;

  vec_t tbl [18];

  task automatic press_ch(input int c);
    nsw[c] = 1'b0;
    repeat (6) @(negedge clk);
    nsw[c] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [NC-1:0] lvl;
    bit            found;

    tbl = '{
      '{4'hF, 4'h0, 10,  0, 1, 0,   1'b0},
      '{4'hD, 4'h0, 3,   1, 0, 0,   1'b0},
      '{4'hF, 4'h0, 1,   1, 0, 0,   1'b0},
      '{4'hD, 4'h0, 3,   1, 0, 0,   1'b0},
      '{4'hF, 4'h0, 10,  1, 0, 0,   1'b0},
      '{4'hD, 4'h0, 4,   1, 0, 0,   1'b0},
      '{4'hF, 4'h0, 10,  1, 1, 0,   1'b0},
      '{4'hB, 4'h0, 10,  2, 1, 0,   1'b0},
      '{4'hF, 4'h0, 90,  2, 1, 0,   1'b0},
      '{4'hB, 4'h0, 10,  2, 2, 100, 1'b0},
      '{4'hF, 4'h0, 27,  2, 2, 100, 1'b0},
      '{4'hB, 4'h0, 10,  2, 3, 37,  1'b0},
      '{4'hF, 4'h0, 10,  2, 3, 37,  1'b0},
      '{4'h7, 4'h0, 10,  3, 1, 0,   1'b0},
      '{4'hF, 4'h0, 200, 3, 1, 0,   1'b0},
      '{4'hF, 4'h0, 100, 3, 1, 255, 1'b1},
      '{4'h7, 4'h0, 10,  3, 2, 255, 1'b0},
      '{4'hF, 4'h0, 10,  3, 2, 255, 1'b0}
    };

    // Reset held with the switches toggling.
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      nsw = 4'(j[0] ? 4'h0 : 4'hA);
      @(negedge clk);
      cmp("rst.press", a_press, 0);
      cmp("rst.count", a_ev, 0);
      cmp("rst.time", a_time, 0);
    end
    nsw = '1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    cmp("idle.count", a_ev, 0);
    cmp("idle.time", a_time, 20);

    // Press latency: first low sample at edge k, pulse only after edge k+5.
    nsw[0] = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      cmp($sformatf("lat.press_j%0d", j), a_press[0], (j == 6) ? 1 : 0);
    end
    cmp("lat.count", fld(a_ev, 0), 1);

    for (int r = 0; r < 18; r++) begin
      nsw = tbl[r].nsw;
      clr = tbl[r].clr;
      repeat (tbl[r].hold) @(negedge clk);
      cmp($sformatf("tbl%0d.count", r), fld(a_ev, tbl[r].ch), tbl[r].ev);
      cmp($sformatf("tbl%0d.period", r), fld(a_per, tbl[r].ch), tbl[r].per);
      cmp($sformatf("tbl%0d.stopped", r), a_stop[tbl[r].ch], tbl[r].stp);
    end

    // Event count wrap on channel 3.
    for (int i = 0; i < 254; i++) begin
      press_ch(3);
      if (i == 252) cmp("wrap.count255", fld(a_ev, 3), 255);
    end
    cmp("wrap.count0", fld(a_ev, 3), 0);

    // Clear colliding with the pulse of the press that would be number six.
    for (int i = 0; i < 4; i++) press_ch(0);
    cmp("clr.pre_count", fld(a_ev, 0), 5);
    nsw[0] = 1'b0;
    found = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      @(negedge clk);
      if (a_press[0]) found = 1;
    end
    cmp("clr.wait_press", found, 1);
    clr = 4'b0001;
    @(negedge clk);
    clr = '0;
    cmp("clr.press_gone", a_press[0], 0);
    cmp("clr.count0", fld(a_ev, 0), 0);
    cmp("clr.period0", fld(a_per, 0), 0);
    cmp("clr.stopped0", a_stop[0], 0);
    cmp("clr.count1", fld(a_ev, 1), 1);
    cmp("clr.count2", fld(a_ev, 2), 3);
    cmp("clr.count3", fld(a_ev, 3), 0);
    nsw[0] = 1'b1;
    repeat (8) @(negedge clk);

    // Random bouncing switches and sporadic clears, with a reset in the middle.
    lvl = '1;
    for (int n = 0; n < 3500; n++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(7) == 0) lvl[c] = ~lvl[c];
        clr[c] = ($urandom_range(63) == 0);
      end
      nsw = lvl;
      rst = (n >= 3000 && n < 3002);
    end
    rst = 1'b0;
    clr = '0;
    nsw = '1;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_capture_unit.md
Name: switch_capture_unit

Overview:
- Parametrised N-channel capture block for the cycle computer's active-low mechanical switches (crank, fork, mode, trip, …).
- Per channel:
  - synchronises and debounces the raw input;
  - emits a one-cycle press pulse;
  - keeps a wrapping event count;
  - measures press-to-press period in prescaled ticks, with saturation and a "stopped" flag.
- A shared free-running tick timer supplies total elapsed time.
- Sits between the pad inputs and the processor subsystem; its counts are read by software.

Parameters:
- N_CH, 4, number of switch channels.
- CNT_W, 16, width of the per-channel event counter and period counter.
- TIME_W, 32, width of the total-time counter.
- DEB_CYCLES, 16, consecutive stable cycles required to accept a level change (≥1).
- PRESC, 1000, clock cycles per timer tick (≥1).

Ports:
- HCLK  in  1  system clock, all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- nSw  in  N_CH  raw active-low switch inputs, asynchronous to HCLK.
- Clear  in  N_CH  per-channel synchronous clear of count/period state.
- Press  out  N_CH  one-cycle pulse per accepted press (high→low debounced).
- Event_count  out  N_CH*CNT_W  press counts; channel i at bits [i*CNT_W +: CNT_W].
- Period  out  N_CH*CNT_W  last press-to-press interval in ticks, same packing.
- Stopped  out  N_CH  channel idle: interval counter saturated.
- Total_time  out  TIME_W  ticks since reset.

Behaviour:
- Reset (HRESET high at an edge):
  - sync flops and debounced state = 1 (released);
  - debounce, prescaler, interval, Event_count, Period, Total_time = 0;
  - Press = 0, Stopped = 0, armed = 0.
  - Reset mid-debounce or mid-interval discards all progress.
- Synchroniser: 2 flops per channel. No logic on the first flop output.
- Debounce, per channel:
  - Counter increments while synced level ≠ debounced state.
  - Counter clears when they are equal.
  - At counter == DEB_CYCLES-1 with levels still differing: debounced state takes the synced level and the counter clears.
  - Glitches shorter than DEB_CYCLES are ignored; the counter restarts on each bounce.
- Press:
  - Registered; high for exactly one cycle on the edge where the debounced state goes 1→0.
  - Release (0→1) is debounced identically but produces no pulse.
  - Latency: first sampling edge of low nSw = edge k → Press visible after edge k+1+DEB_CYCLES.
- Prescaler:
  - Counts 0..PRESC-1; tick = 1 for the cycle the counter equals PRESC-1.
  - Total_time increments on tick and wraps modulo 2^TIME_W.
- Interval counter ic, per channel CNT_W, not exported:
  - On tick with no Press: ic = ic+1, saturating at 2^CNT_W-1.
- On Press:
  - Event_count += 1, wrapping at 2^CNT_W-1 → 0.
  - If armed: Period = sat(ic + tick).
  - ic = 0, armed = 1, Stopped = 0.
  - The first press after reset/Clear leaves Period unchanged.
- Stop detection:
  - When armed and ic reaches 2^CNT_W-1: Period = 2^CNT_W-1 and Stopped = 1.
  - Both hold until the next Press or Clear.
- Clear[i]:
  - Zeroes Event_count, Period, ic, armed, Stopped for channel i on the next edge.
  - Clear wins over a simultaneous Press: the press is not counted and Press still pulses.
  - Debounce state is untouched.
- Channels are fully independent. Simultaneous presses on different channels are all counted.
- All outputs are registered.

Test Plan:
- Reset: hold HRESET 3 cycles with nSw toggling → all outputs 0 and no Press; after release, nSw held high → no activity.
- Clean press (DEB_CYCLES=4): nSw[0] low from edge 10 → Press[0] high only in the cycle after edge 15; Event_count[0]=1; no pulse on release.
- Bounce (DEB_CYCLES=4): nSw[1] low 3 cycles, high 1, low 3, high → no Press[1]. Then low 4 cycles → exactly one Press[1].
- Period (PRESC=1): two debounced presses 100 cycles apart on ch2 → Period[2]=100 after the second; first press leaves Period[2]=0. Third press 37 cycles later → 37.
- Stop (CNT_W=8, PRESC=1): one press then idle 255 cycles → Stopped[3]=1, Period[3]=255. Next press → Stopped[3]=0, Period[3]=255. Event_count wraps 255→0 on the 256th press.
- Clear vs press: Clear[0] in the same cycle Press[0] fires with count 5 → Event_count[0]=0, Period[0]=0, Stopped[0]=0; other channels unchanged.
